// File: rtl/fdiv_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel clock divider.
package fdiv_pkg;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned DEFAULT_DIV_DEF = 0;

    // Ceiling log2, evaluated at elaboration time.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel index width: wide enough to also express index N_CH, so that an
    // out-of-range address can actually be presented and rejected.
    function automatic int unsigned ch_idx_w(input int unsigned n_ch);
        int unsigned w;
        w = clog2(n_ch + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: half-period counter, active/shadow divisor pair,
// square-wave toggle flop and rising-edge tick flop.
module div_channel
    import fdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_data,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q,    tick_d;
    logic             busy_q,    busy_d;
    logic             toggle;

    // Next-state: the active divisor only moves at a toggle (or while idle),
    // and a write landing on that edge goes straight through via shadow_d.
    always_comb begin
        toggle    = (cnt_q == active_q);
        shadow_d  = wr ? wr_data : shadow_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (!en) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            active_d  = shadow_d;
        end else if (toggle) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = ~clk_out_q;
            active_d  = shadow_d;
        end else begin
            cnt_d     = cnt_q + CNT_W'(1);
        end
        busy_d = (shadow_d != active_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            active_q  <= RST_DIV;
            shadow_q  <= RST_DIV;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign busy    = busy_q;

endmodule

// File: rtl/multi_clk_divider.sv
// N-channel programmable clock divider / tick generator: write-address decode
// feeding an array of independent div_channel instances.
module multi_clk_divider
    import fdiv_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int unsigned CH_W       = ch_idx_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_data,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  busy
);

    logic [N_CH-1:0] wr_vec;

    // One-hot write decode; an address >= N_CH matches no channel.
    always_comb begin
        wr_vec = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            wr_vec[i] = wr_en && (wr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .wr      (wr_vec[g]),
            .wr_data (wr_data),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .busy    (busy[g])
        );
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed self-checking bench for multi_clk_divider (N_CH=4, CNT_W=32, DEFAULT_DIV=0).
module tb_multi_clk_divider;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [31:0] wr_data;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  busy;

    int n_checks = 0;
    int n_fail   = 0;

    multi_clk_divider #(
        .N_CH        (4),
        .CNT_W       (32),
        .DEFAULT_DIV (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge; inputs set afterwards apply to the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_div(input int ch, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_ch   = 3'(ch);
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_v;
        rst = 1'b1; en = 4'h0; wr_en = 1'b0; wr_ch = 3'd0; wr_data = 32'd0;
        step(); step();
        rst = 1'b0; en = 4'hF;
        step();
        n_checks++;
        if (clk_out !== 4'hF) begin n_fail++; $display("FAIL pre_reset_clk_out got %h want %h", clk_out, 4'hF); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (clk_out !== 4'h0) begin n_fail++; $display("FAIL async_reset_clk_out got %h want %h", clk_out, 4'h0); end
        n_checks++;
        if (tick !== 4'h0) begin n_fail++; $display("FAIL async_reset_tick got %h want %h", tick, 4'h0); end
        n_checks++;
        if (busy !== 4'h0) begin n_fail++; $display("FAIL async_reset_busy got %h want %h", busy, 4'h0); end
        step();
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_v = (k % 2 == 1) ? 4'hF : 4'h0;
            n_checks++;
            if (clk_out !== exp_v) begin n_fail++; $display("FAIL reset_div2_clk k=%0d got %h want %h", k, clk_out, exp_v); end
            n_checks++;
            if (tick !== exp_v) begin n_fail++; $display("FAIL reset_div2_tick k=%0d got %h want %h", k, tick, exp_v); end
        end
    endtask

    task automatic test_divide();
        int   ph;
        logic exp_c, exp_t;
        en = 4'h0;
        step();
        wr_div(0, 32'd3);
        en = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            ph    = k - 4;
            exp_c = (ph >= 0) && (((ph / 4) % 2) == 0);
            exp_t = (ph >= 0) && ((ph % 8) == 0);
            n_checks++;
            if (clk_out[0] !== exp_c) begin n_fail++; $display("FAIL divide_clk k=%0d got %b want %b", k, clk_out[0], exp_c); end
            n_checks++;
            if (tick[0] !== exp_t) begin n_fail++; $display("FAIL divide_tick k=%0d got %b want %b", k, tick[0], exp_t); end
        end
    endtask

    task automatic test_safe_update();
        logic exp_c, exp_t, exp_b;
        en = 4'h0;
        step();
        wr_div(1, 32'd9);
        en = 4'b0010;
        for (int k = 1; k <= 26; k++) begin
            wr_en   = (k == 15);
            wr_ch   = 3'd1;
            wr_data = 32'd1;
            step();
            exp_c = (k >= 10 && k <= 19) || k == 22 || k == 23 || k == 26;
            exp_t = (k == 10) || (k == 22) || (k == 26);
            exp_b = (k >= 15 && k <= 19);
            n_checks++;
            if (clk_out[1] !== exp_c) begin n_fail++; $display("FAIL safe_update_clk k=%0d got %b want %b", k, clk_out[1], exp_c); end
            n_checks++;
            if (tick[1] !== exp_t) begin n_fail++; $display("FAIL safe_update_tick k=%0d got %b want %b", k, tick[1], exp_t); end
            n_checks++;
            if (busy[1] !== exp_b) begin n_fail++; $display("FAIL safe_update_busy k=%0d got %b want %b", k, busy[1], exp_b); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_boundary_write();
        logic exp_c, exp_t;
        en = 4'h0;
        step();
        wr_div(2, 32'd2);
        en = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            wr_en   = (k == 6);
            wr_ch   = 3'd2;
            wr_data = 32'd5;
            step();
            exp_c = (k >= 3 && k <= 5) || (k >= 12 && k <= 17);
            exp_t = (k == 3) || (k == 12);
            n_checks++;
            if (clk_out[2] !== exp_c) begin n_fail++; $display("FAIL boundary_clk k=%0d got %b want %b", k, clk_out[2], exp_c); end
            n_checks++;
            if (tick[2] !== exp_t) begin n_fail++; $display("FAIL boundary_tick k=%0d got %b want %b", k, tick[2], exp_t); end
            n_checks++;
            if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL boundary_busy k=%0d got %b want 0", k, busy[2]); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_enable();
        int   ph;
        logic exp_c, exp_t;
        en = 4'h0;
        step();
        wr_div(3, 32'd3);
        en = 4'b1000;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_c = (k >= 4);
            exp_t = (k == 4);
            n_checks++;
            if (clk_out[3] !== exp_c) begin n_fail++; $display("FAIL enable_run_clk k=%0d got %b want %b", k, clk_out[3], exp_c); end
            n_checks++;
            if (tick[3] !== exp_t) begin n_fail++; $display("FAIL enable_run_tick k=%0d got %b want %b", k, tick[3], exp_t); end
        end
        en = 4'h0;
        for (int k = 1; k <= 2; k++) begin
            step();
            n_checks++;
            if (clk_out[3] !== 1'b0) begin n_fail++; $display("FAIL en_drop_clk k=%0d got %b want 0", k, clk_out[3]); end
            n_checks++;
            if (tick[3] !== 1'b0) begin n_fail++; $display("FAIL en_drop_tick k=%0d got %b want 0", k, tick[3]); end
        end
        wr_div(3, 32'd4);
        n_checks++;
        if (busy[3] !== 1'b0) begin n_fail++; $display("FAIL idle_write_busy got %b want 0", busy[3]); end
        en = 4'b1000;
        for (int k = 1; k <= 12; k++) begin
            step();
            ph    = k - 5;
            exp_c = (ph >= 0) && (((ph / 5) % 2) == 0);
            exp_t = (ph >= 0) && ((ph % 10) == 0);
            n_checks++;
            if (clk_out[3] !== exp_c) begin n_fail++; $display("FAIL reenable_clk k=%0d got %b want %b", k, clk_out[3], exp_c); end
            n_checks++;
            if (tick[3] !== exp_t) begin n_fail++; $display("FAIL reenable_tick k=%0d got %b want %b", k, tick[3], exp_t); end
        end
    endtask

    task automatic test_max_div();
        en = 4'h0;
        step();
        wr_div(0, 32'hFFFF_FFFF);
        en = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            step();
            n_checks++;
            if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL max_div_hold k=%0d got clk=%b tick=%b want 0/0", k, clk_out[0], tick[0]);
            end
        end
    endtask

    task automatic test_independence();
        int tick_cnt [4];
        int exp_cnt  [4];
        exp_cnt = '{50, 33, 25, 13};
        for (int i = 0; i < 4; i++) tick_cnt[i] = 0;
        en = 4'h0;
        step();
        wr_div(0, 32'd1);
        wr_div(1, 32'd2);
        wr_div(2, 32'd3);
        wr_div(3, 32'd7);
        wr_div(4, 32'd0);
        n_checks++;
        if (busy !== 4'h0) begin n_fail++; $display("FAIL oob_write_busy got %h want 0", busy); end
        en = 4'hF;
        for (int k = 1; k <= 200; k++) begin
            step();
            for (int i = 0; i < 4; i++) if (tick[i] === 1'b1) tick_cnt[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tick_cnt[i] !== exp_cnt[i]) begin
                n_fail++;
                $display("FAIL independence_ticks ch%0d got %0d want %0d", i, tick_cnt[i], exp_cnt[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_safe_update();
        test_boundary_write();
        test_enable();
        test_max_div();
        test_independence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
